// File: rtl/inst_fetch_pkg.sv
// Shared types for the fetch unit: address width, fetch FSM encodings and fault cause codes.
package inst_fetch_pkg;

  localparam int ADDR_LEN = 32;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_DRAIN = 3'd3,
    FS_HOLD  = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_cause_e;

endpackage

// File: rtl/fetch_timer.sv
// Saturating wait-cycle counter; expired is a registered-count compare, no added latency.
// Counts only while en is high; clr has priority and restarts the count at zero.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so a drain entered at the last count still expires after saturation.
  assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: PC -> imem req/gnt/rvalid -> registered instruction/fault held for the decoder.
// Best case 2 cycles REQ->inst_valid; decoder backpressure holds the entry and stalls the PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic                flush,
  output logic                pc_stall,
  output logic                imem_req,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst_o,
  output logic [ADDR_LEN-1:0] inst_pc_o,
  output logic                inst_fault,
  output logic [1:0]          fault_cause
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;
  logic                inst_fault_q, inst_fault_d;
  fault_cause_e        fault_cause_q, fault_cause_d;
  logic                timer_clr, timer_en, timer_expired;
  logic                misaligned;

  assign misaligned = |pc_i[1:0];

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_fault_d  = inst_fault_q;
    fault_cause_d = fault_cause_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      FS_IDLE: state_d = FS_REQ;

      FS_REQ: begin
        // A grant seen alongside flush is void; the memory drops that request.
        if (!flush) begin
          if (misaligned) begin
            inst_d        = '0;
            inst_pc_d     = pc_i;
            inst_fault_d  = 1'b1;
            fault_cause_d = FAULT_MISALIGN;
            state_d       = FS_HOLD;
          end else if (imem_gnt) begin
            fetch_pc_d = pc_i;
            timer_clr  = 1'b1;
            state_d    = FS_WAIT;
          end
        end
      end

      FS_WAIT: begin
        timer_en = 1'b1;
        if (flush) begin
          state_d = FS_DRAIN;
        end else if (imem_rvalid) begin
          inst_d        = imem_rdata;
          inst_pc_d     = fetch_pc_q;
          inst_fault_d  = 1'b0;
          fault_cause_d = FAULT_NONE;
          state_d       = FS_HOLD;
        end else if (timer_expired) begin
          inst_d        = '0;
          inst_pc_d     = fetch_pc_q;
          inst_fault_d  = 1'b1;
          fault_cause_d = FAULT_TIMEOUT;
          state_d       = FS_HOLD;
        end
      end

      FS_DRAIN: begin
        timer_en = 1'b1;
        if (imem_rvalid || timer_expired) begin
          state_d = FS_REQ;
        end
      end

      FS_HOLD: begin
        if (flush || inst_ready) begin
          state_d = FS_REQ;
        end
      end

      default: state_d = FS_IDLE;
    endcase

    inst_valid_d = (state_d == FS_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FS_IDLE;
      fetch_pc_q    <= '0;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      inst_fault_q  <= 1'b0;
      fault_cause_q <= FAULT_NONE;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_fault_q  <= inst_fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  // PC is frozen across REQ/WAIT, so the address can come straight from pc_i.
  assign imem_req    = (state_q == FS_REQ) && !misaligned;
  assign imem_addr   = imem_req ? pc_i : '0;
  assign pc_stall    = !((inst_valid_q && inst_ready) || flush);
  assign inst_valid  = inst_valid_q;
  assign inst_o      = inst_q;
  assign inst_pc_o   = inst_pc_q;
  assign inst_fault  = inst_fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a short timeout so the timeout paths run quickly.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        flush;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_fault;
  logic [1:0]  fault_cause;

  int checks   = 0;
  int failures = 0;

  inst_fetch #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_i        (pc_i),
    .flush       (flush),
    .pc_stall    (pc_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_fault  (inst_fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'd0);
    chk({tag, "_vld"},   32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst_o, 32'd0);
    chk({tag, "_pc"},    inst_pc_o, 32'd0);
    chk({tag, "_fault"}, 32'(inst_fault), 32'd0);
    chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
    chk({tag, "_stall"}, 32'(pc_stall), 32'd1);
  endtask

  // Accept the entry in HOLD; leaves the DUT in REQ one cycle later.
  task automatic accept(input string tag);
    inst_ready = 1'b1;
    #2;
    chk({tag, "_acc_stall"}, 32'(pc_stall), 32'd0);
    tick();
    inst_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    pc_i        = 32'h0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;

    tick();
    tick();
    #2;
    check_reset_outputs("rst");
    flush = 1'b1;
    #1;
    chk("rst_flush_stall", 32'(pc_stall), 32'd0);
    flush = 1'b0;

    // Best-case fetch from PC 0.
    tick();
    rst_n = 1'b1;
    tick();                      // REQ
    imem_gnt = 1'b1;
    #2;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();                      // WAIT
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    #2;
    chk("t1_wait_vld", 32'(inst_valid), 32'd0);
    chk("t1_wait_stall", 32'(pc_stall), 32'd1);
    tick();                      // HOLD
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #2;
    chk("t1_vld", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst_o, 32'h0050_0093);
    chk("t1_pc", inst_pc_o, 32'h0);
    chk("t1_fault", 32'(inst_fault), 32'd0);

    // Decoder backpressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      chk("bp_vld", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst_o, 32'h0050_0093);
      chk("bp_pc", inst_pc_o, 32'h0);
      chk("bp_stall", 32'(pc_stall), 32'd1);
    end
    accept("t1");
    pc_i = 32'h4;
    #2;
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_addr", imem_addr, 32'h4);
    chk("t2_vld_drop", 32'(inst_valid), 32'd0);
    chk("t2_stall", 32'(pc_stall), 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    #2;
    chk("t2_inst", inst_o, 32'h00A0_0113);
    chk("t2_pc", inst_pc_o, 32'h4);
    accept("t2");

    // Misaligned PC: no request, fault one cycle after REQ entry.
    pc_i = 32'h6;
    #2;
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_addr", imem_addr, 32'h0);
    tick();
    #2;
    chk("mis_vld", 32'(inst_valid), 32'd1);
    chk("mis_fault", 32'(inst_fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd1);
    chk("mis_pc", inst_pc_o, 32'h6);
    accept("mis");

    // Timeout: grant, no rvalid; fault visible 5 cycles after grant.
    pc_i     = 32'h8;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    chk("to_early_vld", 32'(inst_valid), 32'd0);
    tick();
    #2;
    chk("to_vld", 32'(inst_valid), 32'd1);
    chk("to_fault", 32'(inst_fault), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd2);
    chk("to_inst", inst_o, 32'h0);
    chk("to_pc", inst_pc_o, 32'h8);
    accept("to");

    // rvalid on the last WAIT cycle beats the timeout.
    pc_i     = 32'hC;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0;
    #2;
    chk("late_vld", 32'(inst_valid), 32'd1);
    chk("late_fault", 32'(inst_fault), 32'd0);
    chk("late_cause", 32'(fault_cause), 32'd0);
    chk("late_inst", inst_o, 32'h1234_5678);
    chk("late_pc", inst_pc_o, 32'hC);
    accept("late");

    // Flush in WAIT, orphaned response discarded, refetch from redirect target.
    pc_i     = 32'h10;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    flush    = 1'b1;
    #2;
    chk("fl_stall", 32'(pc_stall), 32'd0);
    tick();                      // DRAIN
    flush = 1'b0;
    pc_i  = 32'h100;
    #2;
    chk("fl_drain_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #2;
    chk("fl_drain_vld", 32'(inst_valid), 32'd0);
    tick();                      // REQ
    imem_rvalid = 1'b0;
    #2;
    chk("fl_vld", 32'(inst_valid), 32'd0);
    chk("fl_req", 32'(imem_req), 32'd1);
    chk("fl_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    tick();
    imem_rvalid = 1'b0;
    #2;
    chk("fl_inst", inst_o, 32'h0000_0013);
    chk("fl_pc", inst_pc_o, 32'h100);

    // Flush while holding drops the entry.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2;
    chk("flh_vld", 32'(inst_valid), 32'd0);
    chk("flh_req", 32'(imem_req), 32'd1);

    // Reset during WAIT, stray rvalid afterwards.
    pc_i     = 32'h200;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_reset_outputs("mrst");
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    #2;
    chk("mrst_idle_vld", 32'(inst_valid), 32'd0);
    chk("mrst_idle_req", 32'(imem_req), 32'd0);
    tick();                      // REQ, no grant
    #2;
    chk("mrst_req", 32'(imem_req), 32'd1);
    chk("mrst_req_vld", 32'(inst_valid), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    #2;
    chk("mrst_req2_vld", 32'(inst_valid), 32'd0);
    chk("mrst_req2_inst", inst_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
